// File: rtl/pipe_ctrl_decoder_if.sv
// ID-to-EX control bundle: ID-stage instruction fields plus pipeline
// control going in, registered EX control bundle and hazard status out.
interface pipe_ctrl_decoder_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int BTYPE_W = 3,
  parameter int CNT_W   = 16
);
  // ID stage / pipeline control
  logic               id_valid_i;
  logic [OP_W-1:0]    id_instr_op_i;
  logic [4:0]         id_rs_i;
  logic [4:0]         id_rt_i;
  logic               stall_i;
  logic               flush_i;
  // EX stage control bundle
  logic               ex_valid_o;
  logic [4:0]         ex_rt_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic               ex_alu_src_o;
  logic               ex_reg_write_o;
  logic               ex_reg_dst_o;
  logic               ex_branch_o;
  logic               ex_mem_to_reg_o;
  logic               ex_mem_read_o;
  logic               ex_mem_write_o;
  logic               ex_jump_o;
  logic [BTYPE_W-1:0] ex_branch_type_o;
  // status
  logic               stall_o;
  logic               illegal_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  // Side that feeds the ID stage and observes EX
  modport master (
    output id_valid_i, id_instr_op_i, id_rs_i, id_rt_i, stall_i, flush_i,
    input  ex_valid_o, ex_rt_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
           ex_reg_dst_o, ex_branch_o, ex_mem_to_reg_o, ex_mem_read_o,
           ex_mem_write_o, ex_jump_o, ex_branch_type_o, stall_o, illegal_o,
           bubble_cnt_o
  );

  // The decoder itself
  modport slave (
    input  id_valid_i, id_instr_op_i, id_rs_i, id_rt_i, stall_i, flush_i,
    output ex_valid_o, ex_rt_o, ex_alu_op_o, ex_alu_src_o, ex_reg_write_o,
           ex_reg_dst_o, ex_branch_o, ex_mem_to_reg_o, ex_mem_read_o,
           ex_mem_write_o, ex_jump_o, ex_branch_type_o, stall_o, illegal_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl_decoder.sv
// Pipelined MIPS main control: decodes the ID opcode, detects load-use
// hazards, and registers the control bundle into the ID/EX boundary with
// bubble insertion, stall/flush handling, a sticky illegal flag and a
// saturating bubble counter.
module pipe_ctrl_decoder #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int BTYPE_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  pipe_ctrl_decoder_if.slave bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BLE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LI    = OP_W'(15);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  // decoded (combinational) control bundle
  logic [2:0] dec_alu_op;
  logic       dec_alu_src, dec_reg_write, dec_reg_dst, dec_branch;
  logic       dec_mem_to_reg, dec_mem_read, dec_mem_write, dec_jump;
  logic [2:0] dec_btype;
  logic       dec_illegal;
  logic       uses_rs, uses_rt, hz;

  // registered EX bundle
  logic               valid_reg;
  logic [4:0]         rt_reg;
  logic [ALUOP_W-1:0] alu_op_reg;
  logic               alu_src_reg, reg_write_reg, reg_dst_reg, branch_reg;
  logic               mem_to_reg_reg, mem_read_reg, mem_write_reg, jump_reg;
  logic [BTYPE_W-1:0] btype_reg;
  logic               illegal_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Opcode decode table; unlisted opcodes decode to all-zero and illegal
  always_comb begin
    dec_alu_op     = 3'b000;
    dec_alu_src    = 1'b0;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_branch     = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_jump       = 1'b0;
    dec_btype      = 3'b000;
    dec_illegal    = 1'b0;
    case (bus.id_instr_op_i)
      OP_RTYPE: begin dec_alu_op = 3'b010; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
      OP_BLTZ:  begin dec_alu_op = 3'b001; dec_branch = 1'b1; dec_btype = 3'b101; end
      OP_J:     begin dec_jump = 1'b1; end
      OP_JAL:   begin dec_reg_write = 1'b1; dec_jump = 1'b1; end
      OP_BEQ:   begin dec_alu_op = 3'b110; dec_branch = 1'b1; dec_btype = 3'b001; end
      OP_BNE:   begin dec_alu_op = 3'b110; dec_branch = 1'b1; dec_btype = 3'b010; end
      OP_BLE:   begin dec_alu_op = 3'b001; dec_branch = 1'b1; dec_btype = 3'b011; end
      OP_ADDI:  begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_SLTIU: begin dec_alu_op = 3'b001; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_ORI:   begin dec_alu_op = 3'b100; dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_LI:    begin dec_alu_src = 1'b1; dec_reg_write = 1'b1; end
      OP_LW: begin
        dec_alu_op     = 3'b101;
        dec_alu_src    = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_mem_read   = 1'b1;
      end
      OP_SW:    begin dec_alu_op = 3'b101; dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      default:  dec_illegal = 1'b1;
    endcase
  end

  // Which source registers the ID instruction actually reads
  always_comb begin
    uses_rs = !((bus.id_instr_op_i == OP_J) || (bus.id_instr_op_i == OP_JAL) ||
                (bus.id_instr_op_i == OP_LI));
    uses_rt = (bus.id_instr_op_i == OP_RTYPE) || (bus.id_instr_op_i == OP_BEQ) ||
              (bus.id_instr_op_i == OP_BNE)   || (bus.id_instr_op_i == OP_SW);
  end

  // Load-use hazard: a valid load in EX writes a register the ID op reads ($0 never hazards)
  always_comb begin
    hz = bus.id_valid_i && valid_reg && mem_read_reg && (rt_reg != 5'd0) &&
         ((uses_rs && (bus.id_rs_i == rt_reg)) || (uses_rt && (bus.id_rt_i == rt_reg)));
  end

  assign bus.stall_o = hz && !bus.flush_i;

  // ID/EX register: reset > flush > external stall > hazard bubble > load
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i || (!bus.stall_i && hz)) begin
      valid_reg      <= 1'b0;
      rt_reg         <= '0;
      alu_op_reg     <= '0;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      reg_dst_reg    <= 1'b0;
      branch_reg     <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      jump_reg       <= 1'b0;
      btype_reg      <= '0;
    end else if (!bus.stall_i) begin
      valid_reg      <= bus.id_valid_i;
      rt_reg         <= bus.id_valid_i ? bus.id_rt_i : 5'd0;
      alu_op_reg     <= bus.id_valid_i ? ALUOP_W'(dec_alu_op) : '0;
      alu_src_reg    <= bus.id_valid_i && dec_alu_src;
      reg_write_reg  <= bus.id_valid_i && dec_reg_write;
      reg_dst_reg    <= bus.id_valid_i && dec_reg_dst;
      branch_reg     <= bus.id_valid_i && dec_branch;
      mem_to_reg_reg <= bus.id_valid_i && dec_mem_to_reg;
      mem_read_reg   <= bus.id_valid_i && dec_mem_read;
      mem_write_reg  <= bus.id_valid_i && dec_mem_write;
      jump_reg       <= bus.id_valid_i && dec_jump;
      btype_reg      <= bus.id_valid_i ? BTYPE_W'(dec_btype) : '0;
    end
  end

  // Sticky illegal flag and saturating bubble counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (!bus.flush_i && !bus.stall_i) begin
      if (hz) begin
        if (cnt_reg != {CNT_W{1'b1}}) cnt_reg <= cnt_reg + 1'b1;
      end else if (bus.id_valid_i && dec_illegal) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  assign bus.ex_valid_o       = valid_reg;
  assign bus.ex_rt_o          = rt_reg;
  assign bus.ex_alu_op_o      = alu_op_reg;
  assign bus.ex_alu_src_o     = alu_src_reg;
  assign bus.ex_reg_write_o   = reg_write_reg;
  assign bus.ex_reg_dst_o     = reg_dst_reg;
  assign bus.ex_branch_o      = branch_reg;
  assign bus.ex_mem_to_reg_o  = mem_to_reg_reg;
  assign bus.ex_mem_read_o    = mem_read_reg;
  assign bus.ex_mem_write_o   = mem_write_reg;
  assign bus.ex_jump_o        = jump_reg;
  assign bus.ex_branch_type_o = btype_reg;
  assign bus.illegal_o        = illegal_reg;
  assign bus.bubble_cnt_o     = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl_decoder.sv
// Bench for pipe_ctrl_decoder: directed steps followed by randomized traffic,
// each checked against a table-driven reference model of the ID/EX stage.
module tb_pipe_ctrl_decoder;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_decoder_if #(.CNT_W(CNT_W)) bus ();
  pipe_ctrl_decoder #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct packed {
    logic [2:0] alu;
    logic src, rw, rd, br, m2r, mr, mw, j;
    logic [2:0] bt;
  } ctrl_t;

  // reference table and model state
  ctrl_t tbl [64];
  bit    legal [64];
  bit    m_valid, m_ill;
  int    m_rt, m_cnt;
  ctrl_t m_ctrl;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags = {src, rw, rd, br, m2r, mr, mw, j}
  function automatic void set_row(int op, logic [2:0] alu, logic [7:0] f, logic [2:0] bt);
    tbl[op]   = '{alu, f[7], f[6], f[5], f[4], f[3], f[2], f[1], f[0], bt};
    legal[op] = 1'b1;
  endfunction

  function automatic ctrl_t dut_ctrl();
    return '{bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_write_o, bus.ex_reg_dst_o,
             bus.ex_branch_o, bus.ex_mem_to_reg_o, bus.ex_mem_read_o,
             bus.ex_mem_write_o, bus.ex_jump_o, bus.ex_branch_type_o};
  endfunction

  // One clock of traffic: drive, check combinational stall, advance model, check EX
  task automatic step(string tag, bit v, int op, int rs, int rt, bit st, bit fl, bit r);
    bit hz, urs, urt;
    bus.id_valid_i    = v;
    bus.id_instr_op_i = 6'(op);
    bus.id_rs_i       = 5'(rs);
    bus.id_rt_i       = 5'(rt);
    bus.stall_i       = st;
    bus.flush_i       = fl;
    rst               = r;
    #1;
    urs = !(op inside {2, 3, 15});
    urt = op inside {0, 4, 5, 43};
    hz  = v && m_valid && m_ctrl.mr && (m_rt != 0) &&
          ((urs && rs == m_rt) || (urt && rt == m_rt));
    chk({tag, ".stall"}, 32'(bus.stall_o), 32'(hz && !fl));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_rt = 0; m_ctrl = '0; m_ill = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_rt = 0; m_ctrl = '0;
    end else if (st) begin
      // EX holds
    end else if (hz) begin
      m_valid = 0; m_rt = 0; m_ctrl = '0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_valid = v;
      m_rt    = v ? rt : 0;
      m_ctrl  = v ? tbl[op] : '0;
      if (v && !legal[op]) m_ill = 1;
    end
    @(negedge clk);
    chk({tag, ".valid"},   32'(bus.ex_valid_o),   32'(m_valid));
    chk({tag, ".rt"},      32'(bus.ex_rt_o),      32'(m_rt));
    chk({tag, ".ctrl"},    32'(dut_ctrl()),       32'(m_ctrl));
    chk({tag, ".illegal"}, 32'(bus.illegal_o),    32'(m_ill));
    chk({tag, ".cnt"},     32'(bus.bubble_cnt_o), 32'(m_cnt));
    $display("step %-10s v=%0b op=%0d rs=%0d rt=%0d st=%0b fl=%0b rst=%0b -> ex_valid=%0b cnt=%0d ill=%0b",
             tag, v, op, rs, rt, st, fl, r, bus.ex_valid_o, bus.bubble_cnt_o, bus.illegal_o);
  endtask

  initial begin : main
    int ops [17] = '{0, 1, 2, 3, 4, 5, 6, 8, 11, 13, 15, 35, 43, 7, 63, 35, 35};
    for (int i = 0; i < 64; i++) begin tbl[i] = '0; legal[i] = 1'b0; end
    set_row(0,  3'b010, 8'b0110_0000, 3'b000);
    set_row(1,  3'b001, 8'b0001_0000, 3'b101);
    set_row(2,  3'b000, 8'b0000_0001, 3'b000);
    set_row(3,  3'b000, 8'b0100_0001, 3'b000);
    set_row(4,  3'b110, 8'b0001_0000, 3'b001);
    set_row(5,  3'b110, 8'b0001_0000, 3'b010);
    set_row(6,  3'b001, 8'b0001_0000, 3'b011);
    set_row(8,  3'b000, 8'b1100_0000, 3'b000);
    set_row(11, 3'b001, 8'b1100_0000, 3'b000);
    set_row(13, 3'b100, 8'b1100_0000, 3'b000);
    set_row(15, 3'b000, 8'b1100_0000, 3'b000);
    set_row(35, 3'b101, 8'b1100_1100, 3'b000);
    set_row(43, 3'b101, 8'b1000_0010, 3'b000);
    m_valid = 0; m_rt = 0; m_ctrl = '0; m_ill = 0; m_cnt = 0;
    bus.id_valid_i = 0; bus.id_instr_op_i = '0; bus.id_rs_i = '0; bus.id_rt_i = '0;
    bus.stall_i = 0; bus.flush_i = 0;
    @(negedge clk);

    step("reset", 0, 0, 0, 0, 0, 0, 1);
    // table rows
    step("lw", 1, 35, 1, 2, 0, 0, 0);
    chk("lw.alu_op", 32'(bus.ex_alu_op_o), 32'h5);
    chk("lw.mem_read", 32'(bus.ex_mem_read_o), 32'h1);
    step("sw", 1, 43, 3, 4, 0, 0, 0);
    chk("sw.reg_write", 32'(bus.ex_reg_write_o), 32'h0);
    step("rtype", 1, 0, 5, 6, 0, 0, 0);
    step("beq", 1, 4, 5, 6, 0, 0, 0);
    step("jal", 1, 3, 0, 31, 0, 0, 0);
    chk("jal.jump", 32'(bus.ex_jump_o), 32'h1);
    // load-use with rs
    step("lw8", 1, 35, 1, 8, 0, 0, 0);
    step("use8", 1, 0, 8, 3, 0, 0, 0);
    chk("bubble.cnt1", 32'(bus.bubble_cnt_o), 32'h1);
    step("use8b", 1, 0, 8, 3, 0, 0, 0);
    // rt=0 never hazards; li ignores rs
    step("lw0", 1, 35, 1, 0, 0, 0, 0);
    step("use0", 1, 0, 0, 0, 0, 0, 0);
    step("lw9", 1, 35, 1, 9, 0, 0, 0);
    step("li9", 1, 15, 9, 1, 0, 0, 0);
    // flush with stall and a would-be hazard
    step("lw10", 1, 35, 1, 10, 0, 0, 0);
    step("flush", 1, 4, 10, 10, 1, 1, 0);
    // illegal stays sticky
    step("ill7", 1, 7, 0, 0, 0, 0, 0);
    step("addi", 1, 8, 1, 2, 0, 0, 0);
    chk("illegal.sticky", 32'(bus.illegal_o), 32'h1);
    // saturation: 5 load-use hazards
    for (int k = 0; k < 5; k++) begin
      step("sat.lw", 1, 35, 0, 5, 0, 0, 0);
      step("sat.use", 1, 0, 5, 0, 0, 0, 0);
    end
    chk("bubble.sat", 32'(bus.bubble_cnt_o), 32'(CNT_MAX));
    // reset mid-stall
    step("lw12", 1, 35, 1, 12, 0, 0, 0);
    step("rst.stall", 1, 0, 12, 0, 0, 0, 1);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(99) < 85),
           ops[$urandom_range(16)],
           $urandom_range(3), $urandom_range(3),
           ($urandom_range(99) < 10),
           ($urandom_range(99) < 10),
           ($urandom_range(199) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_decoder.md
Name: pipe_ctrl_decoder

Overview:
- Next-generation main control unit for the pipelined MIPS core: decodes the ID-stage opcode and registers the control bundle into the ID/EX boundary.
- Adds load-use hazard detection with bubble insertion, external stall/flush, a sticky illegal-opcode flag and a saturating bubble counter.
- Sits between the IF/ID register and the EX stage.
- Drives EX-stage ALU control, mux selects, memory enables and branch/jump resolution inputs.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALU_op field width; codes are zero-extended when ALUOP_W > 3
BTYPE_W, 3, branch-type field width; codes are zero-extended when BTYPE_W > 3
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  ID stage holds a real instruction
id_instr_op_i  in  OP_W  opcode, instr[31:26]
id_rs_i  in  5  rs field
id_rt_i  in  5  rt field
stall_i  in  1  external stall (memory wait); holds the EX register
flush_i  in  1  branch/jump taken; kill the ID instruction
ex_valid_o  out  1  EX holds a real instruction
ex_rt_o  out  5  registered rt
ex_alu_op_o  out  ALUOP_W  registered ALU op
ex_alu_src_o  out  1  registered ALUSrc
ex_reg_write_o  out  1  registered RegWrite
ex_reg_dst_o  out  1  registered RegDst
ex_branch_o  out  1  registered Branch
ex_mem_to_reg_o  out  1  registered MemtoReg
ex_mem_read_o  out  1  registered MemRead
ex_mem_write_o  out  1  registered MemWrite
ex_jump_o  out  1  registered Jump
ex_branch_type_o  out  BTYPE_W  registered branch type
stall_o  out  1  load-use hazard detected; hold PC and IF/ID (combinational)
illegal_o  out  1  sticky flag: an unknown opcode was loaded
bubble_cnt_o  out  CNT_W  count of inserted bubbles, saturating

Behaviour:
Decode table (combinational). Fields: alu_op / ALUSrc / RegWrite / RegDst / Branch / MemtoReg / MemRead / MemWrite / Jump / btype. Any field not listed is 0.
- op 0 (R-type, jr): alu_op 010; RegWrite, RegDst.
- op 1 (bltz): alu_op 001; Branch; btype 101.
- op 2 (j): alu_op 000; Jump.
- op 3 (jal): alu_op 000; RegWrite, Jump.
- op 4 (beq): alu_op 110; Branch; btype 001.
- op 5 (bne): alu_op 110; Branch; btype 010.
- op 6 (ble): alu_op 001; Branch; btype 011.
- op 8 (addi): alu_op 000; ALUSrc, RegWrite.
- op 11 (sltiu): alu_op 001; ALUSrc, RegWrite.
- op 13 (ori): alu_op 100; ALUSrc, RegWrite.
- op 15 (li): alu_op 000; ALUSrc, RegWrite.
- op 35 (lw): alu_op 101; ALUSrc, RegWrite, MemtoReg, MemRead.
- op 43 (sw): alu_op 101; ALUSrc, MemWrite.
- Any other op: all fields 0; marked illegal.

Operand use (combinational):
- uses_rs = not op in {2, 3, 15}.
- uses_rt = op in {0, 4, 5, 43}.

Hazard:
- hz = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rt_o != 0) & ((uses_rs & id_rs_i == ex_rt_o) | (uses_rt & id_rt_i == ex_rt_o)).
- stall_o = hz & ~flush_i.

EX register update, evaluated per rising edge in this priority order:
1. rst_i: all ex_* outputs 0, ex_valid_o 0, illegal_o 0, bubble_cnt_o 0.
2. flush_i: load a bubble (all ex_* 0, ex_valid_o 0). Overrides stall_i and hz. Does not increment the counter.
3. stall_i: hold all ex_* outputs; no counter change.
4. hz: load a bubble; bubble_cnt_o increments by 1, saturating at 2^CNT_W-1.
5. Otherwise: load the decode outputs, ex_valid_o = id_valid_i, ex_rt_o = id_rt_i. When id_valid_i=0, ex_* fields are forced to 0.

Illegal flag:
- illegal_o is set only in case 5, with id_valid_i=1 and an illegal opcode.
- It stays set until reset.

Timing:
- Latency is 1 cycle from ID inputs to ex_* outputs.
- stall_o is combinational, in the same cycle as the ID inputs.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_mem_read_o=0, so hz drops.

Test Plan:
- Reset, then sequence op 35, 43, 0, 4, 3 each with id_valid_i=1 -> one cycle later ex_* matches the table row: lw gives alu_op 101, mem_read=1, mem_to_reg=1; sw gives mem_write=1, reg_write=0; jal gives jump=1, reg_write=1.
- lw with rt=8, then next cycle op 0 with rs=8 -> stall_o=1 in that cycle; next edge ex_valid_o=0 and bubble_cnt_o=1; following edge loads the R-type.
- lw with rt=0, then op 0 with rs=0 -> stall_o=0, no bubble.
- lw with rt=9, then li (op 15) with rs=9 -> uses_rs=0, so no stall.
- Assert flush_i and stall_i together with a valid beq in ID -> ex_valid_o=0, all ex_* 0, bubble_cnt_o unchanged.
- Valid op 7 -> illegal_o=1 next edge and stays set across later legal ops. Run with CNT_W=2 and 5 load-use hazards -> bubble_cnt_o saturates at 3. rst_i mid-stall -> every output 0 on that edge.
